// File: rtl/credit_to_time.sv
// Converts a payment in cents into parking seconds with a bit-serial restoring divider
// and feeds a saturating 1 Hz countdown. Define CONV_ROUND_UP_EN to round partial seconds up.
module credit_to_time #(
    parameter int CENTS_W = 14,
    parameter int SEC_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         sw,
    input  logic               tick_1hz,
    input  logic               pay_valid,
    input  logic [CENTS_W-1:0] pay_cents,
    output logic               pay_ready,
    output logic               pay_reject,
    output logic [SEC_W-1:0]   sec_left,
    output logic               busy,
    output logic               expired
);
    localparam int DIV_W = 20;
    localparam int SUM_W = DIV_W + 1;
    localparam logic [SEC_W-1:0] SEC_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        ADD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] quo_q, quo_d;
    logic [7:0]       rem_q, rem_d;
    logic [7:0]       rate_q, rate_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             rej_q, rej_d;

    logic [4:0]       hour;
    logic             hour_ok;
    logic [7:0]       rate_lut;
    logic [DIV_W-1:0] dividend;
    logic [8:0]       rem_shift;
    logic             rem_ge;
    logic [DIV_W-1:0] quot;
    logic             dec;
    logic [SUM_W-1:0] sum;

    always_comb begin
        hour     = sw[4:0];
        hour_ok  = (hour < 5'd24);
        rate_lut = 8'd0;
        if (sw[7:5] == 3'd0) begin
            if (hour <= 5'd7)       rate_lut = 8'd145;
            else if (hour <= 5'd12) rate_lut = 8'd167;
            else if (hour <= 5'd17) rate_lut = 8'd189;
            else                    rate_lut = 8'd145;
        end else begin
            if (hour <= 5'd7)       rate_lut = 8'd134;
            else if (hour <= 5'd12) rate_lut = 8'd156;
            else if (hour <= 5'd17) rate_lut = 8'd178;
            else                    rate_lut = 8'd156;
        end
    end

    assign dividend = DIV_W'(pay_cents) * DIV_W'(60);

    // quo_q holds the dividend; its MSB feeds the partial remainder while quotient bits enter at the LSB.
    assign rem_shift = {rem_q, quo_q[DIV_W-1]};
    assign rem_ge    = (rem_shift >= {1'b0, rate_q});

`ifdef CONV_ROUND_UP_EN
    assign quot = quo_q + DIV_W'(rem_q != 8'd0);
`else
    assign quot = quo_q;
`endif

    assign dec = tick_1hz && (sec_q != '0);
    assign sum = SUM_W'(sec_q) - SUM_W'(dec) + SUM_W'(quot);

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        rate_d  = rate_q;
        cnt_d   = cnt_q;
        rej_d   = 1'b0;
        sec_d   = dec ? (sec_q - SEC_W'(1)) : sec_q;
        case (state_q)
            IDLE: begin
                if (pay_valid) begin
                    if (hour_ok) begin
                        rate_d  = rate_lut;
                        quo_d   = dividend;
                        rem_d   = 8'd0;
                        cnt_d   = 5'd0;
                        state_d = DIV;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            DIV: begin
                // When rem_ge holds the true difference is below rate, so 8-bit wrap is exact.
                rem_d = rem_ge ? (rem_shift[7:0] - rate_q) : rem_shift[7:0];
                quo_d = {quo_q[DIV_W-2:0], rem_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_W - 1)) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                sec_d   = (sum > SUM_W'(SEC_MAX)) ? SEC_MAX : sum[SEC_W-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            rate_q  <= '0;
            cnt_q   <= '0;
            sec_q   <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            sec_q   <= sec_d;
            rej_q   <= rej_d;
        end
    end

    assign pay_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign pay_reject = rej_q;
    assign sec_left   = sec_q;
    assign expired    = (sec_q == '0);
endmodule
